id_stage: RTL and testbench

Parametrised, pipelined instruction-decode stage between fetch and execute. It decodes RV32I/RV64I base integer instructions into a registered control bundle carrying the sign-extended immediate. It supports an optional M-extension. Upstream and downstream use valid/ready handshakes, and a two-entry skid buffer sustains one instruction per cycle under backpressure. A flush input discards in-flight instructions on redirect.

---
 rtl/id_stage.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Brief    : RV32I/RV64I decode stage with valid/ready handshakes, a
//            two-entry skid buffer and flush. Define ID_M_EXT_EN to decode
//            the M-extension (MUL..REMU).
// Revision : 1.0 - initial release
// ============================================================================
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_inst_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_rd_we_o,
  output logic            ex_src2_imm_o,
  output logic [4:0]      ex_alu_op_o,
  output logic [3:0]      ex_mem_op_o,
  output logic            ex_mem_uns_o,
  output logic [3:0]      ex_br_op_o,
  output logic            ex_illegal_o
);

  localparam bit c_IS64 = (XLEN == 64);
  localparam int c_SHW  = c_IS64 ? 6 : 5;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

  localparam logic [4:0] c_ALU_ADD   = 5'd0;
  localparam logic [4:0] c_ALU_SUB   = 5'd1;
  localparam logic [4:0] c_ALU_SLL   = 5'd2;
  localparam logic [4:0] c_ALU_SLT   = 5'd3;
  localparam logic [4:0] c_ALU_SLTU  = 5'd4;
  localparam logic [4:0] c_ALU_XOR   = 5'd5;
  localparam logic [4:0] c_ALU_SRL   = 5'd6;
  localparam logic [4:0] c_ALU_SRA   = 5'd7;
  localparam logic [4:0] c_ALU_OR    = 5'd8;
  localparam logic [4:0] c_ALU_AND   = 5'd9;
  localparam logic [4:0] c_ALU_PASSB = 5'd10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic            src2_imm;
    logic [4:0]      alu_op;
    logic [3:0]      mem_op;
    logic            mem_uns;
    logic [3:0]      br_op;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  function automatic logic [4:0] f3_alu(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? c_ALU_SUB : c_ALU_ADD;
      3'b001:  op = c_ALU_SLL;
      3'b010:  op = c_ALU_SLT;
      3'b011:  op = c_ALU_SLTU;
      3'b100:  op = c_ALU_XOR;
      3'b101:  op = alt ? c_ALU_SRA : c_ALU_SRL;
      3'b110:  op = c_ALU_OR;
      default: op = c_ALU_AND;
    endcase
    return op;
  endfunction

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_sh;
  logic            w_legal;
  logic            w_we_fmt;
  bundle_t         w_dec;

  assign w_opc = if_inst_i[6:0];
  assign w_rd  = if_inst_i[11:7];
  assign w_f3  = if_inst_i[14:12];
  assign w_rs1 = if_inst_i[19:15];
  assign w_rs2 = if_inst_i[24:20];
  assign w_f7  = if_inst_i[31:25];

  assign w_imm_i  = {{(XLEN-12){if_inst_i[31]}}, if_inst_i[31:20]};
  assign w_imm_s  = {{(XLEN-12){if_inst_i[31]}}, if_inst_i[31:25], if_inst_i[11:7]};
  assign w_imm_b  = {{(XLEN-13){if_inst_i[31]}}, if_inst_i[31], if_inst_i[7],
                     if_inst_i[30:25], if_inst_i[11:8], 1'b0};
  assign w_imm_j  = {{(XLEN-21){if_inst_i[31]}}, if_inst_i[31], if_inst_i[19:12],
                     if_inst_i[20], if_inst_i[30:21], 1'b0};
  assign w_imm_sh = {{(XLEN-c_SHW){1'b0}}, if_inst_i[20 +: c_SHW]};

  generate
    if (XLEN > 32) begin : g_imm_u_ext
      assign w_imm_u = {{(XLEN-32){if_inst_i[31]}}, if_inst_i[31:12], 12'h000};
    end else begin : g_imm_u_nat
      assign w_imm_u = {if_inst_i[31:12], 12'h000};
    end
  endgenerate

  always_comb begin
    w_dec    = '0;
    w_legal  = 1'b0;
    w_we_fmt = 1'b0;
    w_dec.pc = if_pc_i;
    case (w_opc)
      c_OPC_OP: begin
        w_dec.rs1    = w_rs1;
        w_dec.rs2    = w_rs2;
        w_dec.rd     = w_rd;
        w_we_fmt     = 1'b1;
        w_dec.alu_op = f3_alu(w_f3, w_f7[5]);
        if (w_f7 == 7'b0000000) begin
          w_legal = 1'b1;
        end else if (w_f7 == 7'b0100000) begin
          w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b101);
`ifdef ID_M_EXT_EN
        end else if (w_f7 == 7'b0000001) begin
          w_legal      = 1'b1;
          w_dec.alu_op = {2'b10, w_f3};
`endif
        end
      end
      c_OPC_OP_IMM: begin
        w_dec.rs1      = w_rs1;
        w_dec.rd       = w_rd;
        w_dec.src2_imm = 1'b1;
        w_we_fmt       = 1'b1;
        w_dec.alu_op   = f3_alu(w_f3, (w_f3 == 3'b101) && if_inst_i[30]);
        w_dec.imm      = w_imm_i;
        w_legal        = 1'b1;
        // Shifts carry the zero-extended shamt; bits above it must be clear
        // apart from the SRAI selector.
        if (w_f3 == 3'b001) begin
          w_dec.imm = w_imm_sh;
          w_legal   = c_IS64 ? (if_inst_i[31:26] == 6'b000000)
                             : (if_inst_i[31:25] == 7'b0000000);
        end else if (w_f3 == 3'b101) begin
          w_dec.imm = w_imm_sh;
          w_legal   = c_IS64 ? ((if_inst_i[31:26] == 6'b000000) || (if_inst_i[31:26] == 6'b010000))
                             : ((if_inst_i[31:25] == 7'b0000000) || (if_inst_i[31:25] == 7'b0100000));
        end
      end
      c_OPC_LOAD: begin
        w_dec.rs1      = w_rs1;
        w_dec.rd       = w_rd;
        w_dec.imm      = w_imm_i;
        w_dec.src2_imm = 1'b1;
        w_we_fmt       = 1'b1;
        w_dec.mem_op   = {2'b10, w_f3[1:0]};
        w_dec.mem_uns  = w_f3[2];
        case (w_f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
          3'b011, 3'b110:                         w_legal = c_IS64;
          default:                                w_legal = 1'b0;
        endcase
      end
      c_OPC_STORE: begin
        w_dec.rs1      = w_rs1;
        w_dec.rs2      = w_rs2;
        w_dec.imm      = w_imm_s;
        w_dec.src2_imm = 1'b1;
        w_dec.mem_op   = {2'b11, w_f3[1:0]};
        w_legal        = (w_f3[2] == 1'b0) && ((w_f3[1:0] != 2'b11) || c_IS64);
      end
      c_OPC_BRANCH: begin
        w_dec.rs1   = w_rs1;
        w_dec.rs2   = w_rs2;
        w_dec.imm   = w_imm_b;
        w_dec.br_op = {1'b1, w_f3};
        w_legal     = (w_f3[2:1] != 2'b01);
      end
      c_OPC_LUI, c_OPC_AUIPC: begin
        w_dec.rd       = w_rd;
        w_dec.imm      = w_imm_u;
        w_dec.src2_imm = 1'b1;
        w_dec.alu_op   = (w_opc == c_OPC_LUI) ? c_ALU_PASSB : c_ALU_ADD;
        w_we_fmt       = 1'b1;
        w_legal        = 1'b1;
      end
      c_OPC_JAL: begin
        w_dec.rd       = w_rd;
        w_dec.imm      = w_imm_j;
        w_dec.src2_imm = 1'b1;
        w_dec.br_op    = 4'b1010;
        w_we_fmt       = 1'b1;
        w_legal        = 1'b1;
      end
      c_OPC_JALR: begin
        w_dec.rs1      = w_rs1;
        w_dec.rd       = w_rd;
        w_dec.imm      = w_imm_i;
        w_dec.src2_imm = 1'b1;
        w_dec.br_op    = 4'b1011;
        w_we_fmt       = 1'b1;
        w_legal        = (w_f3 == 3'b000);
      end
      default: w_legal = 1'b0;
    endcase
    // An illegal instruction keeps its fields but carries no side effects.
    if (!w_legal) begin
      w_dec.alu_op   = c_ALU_ADD;
      w_dec.src2_imm = 1'b0;
      w_dec.mem_op   = 4'b0000;
      w_dec.mem_uns  = 1'b0;
      w_dec.br_op    = 4'b0000;
    end
    w_dec.illegal = !w_legal;
    w_dec.rd_we   = w_legal && w_we_fmt && (w_rd != 5'd0);
  end

  // --------------------------------------------------------------------------
  // Skid buffer control
  // --------------------------------------------------------------------------
  state_t  r_state;
  state_t  w_state_nxt;
  bundle_t r_out;
  bundle_t r_skid;
  logic    w_acc_in;
  logic    w_acc_out;
  logic    w_load_out;
  logic    w_load_skid;
  logic    w_skid_to_out;

  assign if_ready_o = (r_state != S_FULL);
  assign ex_valid_o = (r_state != S_EMPTY);
  assign w_acc_in   = if_valid_i && if_ready_o && !flush_i;
  assign w_acc_out  = ex_valid_o && ex_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc_in) begin
            w_state_nxt = S_ONE;
            w_load_out  = 1'b1;
          end
        end
        S_ONE: begin
          if (w_acc_in && w_acc_out) begin
            w_load_out = 1'b1;
          end else if (w_acc_in) begin
            w_state_nxt = S_FULL;
            w_load_skid = 1'b1;
          end else if (w_acc_out) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_acc_out) begin
            w_state_nxt   = S_ONE;
            w_skid_to_out = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_out)         r_out <= w_dec;
      else if (w_skid_to_out) r_out <= r_skid;
      if (w_load_skid)        r_skid <= w_dec;
    end
  end

  assign ex_pc_o       = r_out.pc;
  assign ex_imm_o      = r_out.imm;
  assign ex_rs1_o      = r_out.rs1;
  assign ex_rs2_o      = r_out.rs2;
  assign ex_rd_o       = r_out.rd;
  assign ex_rd_we_o    = r_out.rd_we;
  assign ex_src2_imm_o = r_out.src2_imm;
  assign ex_alu_op_o   = r_out.alu_op;
  assign ex_mem_op_o   = r_out.mem_op;
  assign ex_mem_uns_o  = r_out.mem_uns;
  assign ex_br_op_o    = r_out.br_op;
  assign ex_illegal_o  = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Brief    : Self-checking bench for id_stage; drives XLEN=32 and XLEN=64
//            instances in lockstep against a behavioural decode/queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

`ifdef ID_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  localparam logic [4:0] ALU_TAB [0:7] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
  localparam logic [63:0] MASK32 = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] MASK64 = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        s2i;
    logic [4:0]  alu;
    logic [3:0]  mem;
    logic        uns;
    logic [3:0]  br;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        ex_ready = 1'b0;
  logic [31:0] inst = '0;
  logic [63:0] pc = '0;

  logic        d32_if_ready, d32_ex_valid, d32_we, d32_s2i, d32_uns, d32_ill;
  logic [31:0] d32_pc, d32_imm;
  logic [4:0]  d32_rs1, d32_rs2, d32_rd, d32_alu;
  logic [3:0]  d32_mem, d32_br;

  logic        d64_if_ready, d64_ex_valid, d64_we, d64_s2i, d64_uns, d64_ill;
  logic [63:0] d64_pc, d64_imm;
  logic [4:0]  d64_rs1, d64_rs2, d64_rd, d64_alu;
  logic [3:0]  d64_mem, d64_br;

  int   n_checks = 0;
  int   n_pass = 0;
  txn_t q[$];

  always #5 clk = ~clk;

  id_stage #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .if_valid_i(if_valid), .if_ready_o(d32_if_ready),
    .if_inst_i(inst), .if_pc_i(pc[31:0]),
    .ex_valid_o(d32_ex_valid), .ex_ready_i(ex_ready),
    .ex_pc_o(d32_pc), .ex_imm_o(d32_imm),
    .ex_rs1_o(d32_rs1), .ex_rs2_o(d32_rs2), .ex_rd_o(d32_rd),
    .ex_rd_we_o(d32_we), .ex_src2_imm_o(d32_s2i), .ex_alu_op_o(d32_alu),
    .ex_mem_op_o(d32_mem), .ex_mem_uns_o(d32_uns), .ex_br_op_o(d32_br),
    .ex_illegal_o(d32_ill)
  );

  id_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .if_valid_i(if_valid), .if_ready_o(d64_if_ready),
    .if_inst_i(inst), .if_pc_i(pc),
    .ex_valid_o(d64_ex_valid), .ex_ready_i(ex_ready),
    .ex_pc_o(d64_pc), .ex_imm_o(d64_imm),
    .ex_rs1_o(d64_rs1), .ex_rs2_o(d64_rs2), .ex_rd_o(d64_rd),
    .ex_rd_we_o(d64_we), .ex_src2_imm_o(d64_s2i), .ex_alu_op_o(d64_alu),
    .ex_mem_op_o(d64_mem), .ex_mem_uns_o(d64_uns), .ex_br_op_o(d64_br),
    .ex_illegal_o(d64_ill)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: fields per instruction format, immediates by arithmetic shifts.
  function automatic exp_t model(input logic [31:0] in, input int xlen);
    exp_t   e;
    bit     legal;
    bit     wr;
    int     f3, f7, shw, upper;
    longint s, imm_i, imm_s, imm_b, imm_j, imm_u;
    e     = '0;
    legal = 1'b0;
    wr    = 1'b0;
    f3    = int'(in[14:12]);
    f7    = int'(in[31:25]);
    shw   = (xlen == 64) ? 6 : 5;
    upper = int'(in[31:20]) >> shw;
    s     = longint'($signed(in));
    imm_i = s >>> 20;
    imm_s = ((s >>> 25) << 5) | longint'(in[11:7]);
    imm_b = ((s >>> 31) << 12) | (longint'(in[7]) << 11) | (longint'(in[30:25]) << 5)
          | (longint'(in[11:8]) << 1);
    imm_j = ((s >>> 31) << 20) | (longint'(in[19:12]) << 12) | (longint'(in[20]) << 11)
          | (longint'(in[30:21]) << 1);
    imm_u = s & ~longint'(4095);
    case (in[6:0])
      7'h33: begin
        e.rs1 = in[19:15]; e.rs2 = in[24:20]; e.rd = in[11:7]; wr = 1'b1;
        if (f7 == 0) begin
          legal = 1'b1; e.alu = ALU_TAB[f3];
        end else if (f7 == 32 && (f3 == 0 || f3 == 5)) begin
          legal = 1'b1; e.alu = (f3 == 0) ? 5'd1 : 5'd7;
        end else if (f7 == 1 && M_EN) begin
          legal = 1'b1; e.alu = 5'(16 + f3);
        end
      end
      7'h13: begin
        e.rs1 = in[19:15]; e.rd = in[11:7]; e.s2i = 1'b1; wr = 1'b1;
        if (f3 == 1 || f3 == 5) begin
          e.imm = 64'(longint'(in[31:20]) & ((longint'(1) << shw) - 1));
          if (f3 == 1) begin
            legal = (upper == 0); e.alu = 5'd2;
          end else begin
            legal = (upper == 0) || (upper == (1024 >> shw));
            e.alu = (upper != 0) ? 5'd7 : 5'd6;
          end
        end else begin
          e.imm = 64'(imm_i); legal = 1'b1; e.alu = ALU_TAB[f3];
        end
      end
      7'h03: begin
        e.rs1 = in[19:15]; e.rd = in[11:7]; e.s2i = 1'b1; wr = 1'b1; e.imm = 64'(imm_i);
        legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)
             || (xlen == 64 && (f3 == 3 || f3 == 6));
        e.mem = 4'(8 + (f3 % 4)); e.uns = (f3 >= 4);
      end
      7'h23: begin
        e.rs1 = in[19:15]; e.rs2 = in[24:20]; e.s2i = 1'b1; e.imm = 64'(imm_s);
        legal = (f3 < 3) || (xlen == 64 && f3 == 3);
        e.mem = 4'(12 + (f3 % 4));
      end
      7'h63: begin
        e.rs1 = in[19:15]; e.rs2 = in[24:20]; e.imm = 64'(imm_b);
        legal = (f3 != 2 && f3 != 3); e.br = 4'(8 + f3);
      end
      7'h37: begin
        e.rd = in[11:7]; e.imm = 64'(imm_u); e.s2i = 1'b1; e.alu = 5'd10; wr = 1'b1; legal = 1'b1;
      end
      7'h17: begin
        e.rd = in[11:7]; e.imm = 64'(imm_u); e.s2i = 1'b1; wr = 1'b1; legal = 1'b1;
      end
      7'h6F: begin
        e.rd = in[11:7]; e.imm = 64'(imm_j); e.s2i = 1'b1; e.br = 4'd10; wr = 1'b1; legal = 1'b1;
      end
      7'h67: begin
        e.rs1 = in[19:15]; e.rd = in[11:7]; e.imm = 64'(imm_i); e.s2i = 1'b1; e.br = 4'd11;
        wr = 1'b1; legal = (f3 == 0);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.alu = '0; e.s2i = 1'b0; e.mem = '0; e.uns = 1'b0; e.br = '0;
    end
    e.ill = !legal;
    e.we  = legal && wr && (e.rd != 5'd0);
    return e;
  endfunction

  task automatic check_out(input string who, input exp_t e, input logic [63:0] epc,
                           input logic [63:0] mask, input logic [63:0] pc_o, input logic [63:0] imm_o,
                           input logic [4:0] rs1_o, input logic [4:0] rs2_o, input logic [4:0] rd_o,
                           input logic we_o, input logic s2i_o, input logic [4:0] alu_o,
                           input logic [3:0] mem_o, input logic uns_o, input logic [3:0] br_o,
                           input logic ill_o);
    check({who, ".pc"},   pc_o,  epc & mask);
    check({who, ".imm"},  imm_o, e.imm & mask);
    check({who, ".rs1"},  64'(rs1_o), 64'(e.rs1));
    check({who, ".rs2"},  64'(rs2_o), 64'(e.rs2));
    check({who, ".rd"},   64'(rd_o),  64'(e.rd));
    check({who, ".we"},   64'(we_o),  64'(e.we));
    check({who, ".s2i"},  64'(s2i_o), 64'(e.s2i));
    check({who, ".alu"},  64'(alu_o), 64'(e.alu));
    check({who, ".mem"},  64'(mem_o), 64'(e.mem));
    check({who, ".uns"},  64'(uns_o), 64'(e.uns));
    check({who, ".br"},   64'(br_o),  64'(e.br));
    check({who, ".ill"},  64'(ill_o), 64'(e.ill));
  endtask

  // One clock: scoreboard at the negative edge, then return just after the rising edge.
  task automatic cycle();
    int   occ;
    txn_t t;
    @(negedge clk);
    occ = q.size();
    check("if_ready32", 64'(d32_if_ready), 64'(occ < 2));
    check("ex_valid32", 64'(d32_ex_valid), 64'(occ > 0));
    check("if_ready64", 64'(d64_if_ready), 64'(occ < 2));
    check("ex_valid64", 64'(d64_ex_valid), 64'(occ > 0));
    if (occ > 0 && ex_ready) begin
      t = q.pop_front();
      check_out("out32", model(t.inst, 32), t.pc, MASK32, {32'h0, d32_pc}, {32'h0, d32_imm},
                d32_rs1, d32_rs2, d32_rd, d32_we, d32_s2i, d32_alu, d32_mem, d32_uns, d32_br, d32_ill);
      check_out("out64", model(t.inst, 64), t.pc, MASK64, d64_pc, d64_imm,
                d64_rs1, d64_rs2, d64_rd, d64_we, d64_s2i, d64_alu, d64_mem, d64_uns, d64_br, d64_ill);
    end
    if (flush) begin
      q.delete();
    end else if (if_valid && occ < 2) begin
      t.inst = inst;
      t.pc   = pc;
      q.push_back(t);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 12))
      0:  r[6:0] = 7'h33;
      1:  r[6:0] = 7'h13;
      2:  r[6:0] = 7'h03;
      3:  r[6:0] = 7'h23;
      4:  r[6:0] = 7'h63;
      5:  r[6:0] = 7'h37;
      6:  r[6:0] = 7'h17;
      7:  r[6:0] = 7'h6F;
      8:  r[6:0] = 7'h67;
      9:  r[6:0] = 7'h3B;
      10: r[6:0] = 7'h1B;
      11: r[6:0] = 7'h13;
      default: ;
    endcase
    case ($urandom_range(0, 4))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      3: r[31:26] = 6'h10;
      default: ;
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] p);
    if_valid = v;
    inst     = i;
    pc       = p;
  endtask

  logic [31:0] bp_inst [0:3];
  int          idx;
  logic        acc;

  initial begin
    // Reset state
    #3;
    check("rst.if_ready32", 64'(d32_if_ready), 64'd1);
    check("rst.ex_valid32", 64'(d32_ex_valid), 64'd0);
    check("rst.pc32",       64'(d32_pc),       64'd0);
    check("rst.imm32",      64'(d32_imm),      64'd0);
    check("rst.we32",       64'(d32_we),       64'd0);
    check("rst.alu32",      64'(d32_alu),      64'd0);
    check("rst.ill32",      64'(d32_ill),      64'd0);
    check("rst.br32",       64'(d32_br),       64'd0);
    check("rst.mem32",      64'(d32_mem),      64'd0);
    check("rst.if_ready64", 64'(d64_if_ready), 64'd1);
    check("rst.ex_valid64", 64'(d64_ex_valid), 64'd0);
    check("rst.imm64",      d64_imm,           64'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    ex_ready = 1'b1;

    // addi x1,x0,5
    drive(1'b1, 32'h0050_0093, 64'h100);
    cycle();
    check("addi.valid", 64'(d32_ex_valid), 64'd1);
    check("addi.alu",   64'(d32_alu),      64'd0);
    check("addi.s2i",   64'(d32_s2i),      64'd1);
    check("addi.imm",   64'(d32_imm),      64'h5);
    check("addi.rd",    64'(d32_rd),       64'd1);
    check("addi.we",    64'(d32_we),       64'd1);

    // beq x0,x0,-4
    drive(1'b1, 32'hFE00_0EE3, 64'h104);
    cycle();
    check("beq.imm", 64'(d32_imm), 64'hFFFF_FFFC);
    check("beq.br",  64'(d32_br),  64'h8);
    check("beq.we",  64'(d32_we),  64'd0);

    // sub x3,x1,x2
    drive(1'b1, 32'h4020_81B3, 64'h108);
    cycle();
    check("sub.alu", 64'(d32_alu), 64'd1);
    check("sub.rs1", 64'(d32_rs1), 64'd1);
    check("sub.rs2", 64'(d32_rs2), 64'd2);
    check("sub.rd",  64'(d32_rd),  64'd3);

    // mul x3,x1,x2
    drive(1'b1, 32'h0220_81B3, 64'h10C);
    cycle();
    check("mul.alu", 64'(d32_alu), M_EN ? 64'd16 : 64'd0);
    check("mul.we",  64'(d32_we),  M_EN ? 64'd1 : 64'd0);
    check("mul.ill", 64'(d32_ill), M_EN ? 64'd0 : 64'd1);

    // srai x1,x1,63
    drive(1'b1, 32'h43F0_D093, 64'h110);
    cycle();
    check("srai64.alu",   64'(d64_alu),      64'd7);
    check("srai64.shamt", 64'(d64_imm[5:0]), 64'd63);
    check("srai64.ill",   64'(d64_ill),      64'd0);
    check("srai32.ill",   64'(d32_ill),      64'd1);
    check("srai32.we",    64'(d32_we),       64'd0);

    drive(1'b0, 32'h0, 64'h0);
    cycle();
    cycle();

    // Backpressure: four instructions, ex_ready low for three cycles
    bp_inst[0] = 32'h0010_0113;
    bp_inst[1] = 32'h0020_0193;
    bp_inst[2] = 32'h0030_0213;
    bp_inst[3] = 32'h0040_0293;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      ex_ready = (c >= 3);
      drive(idx < 4, (idx < 4) ? bp_inst[idx] : 32'h0, 64'h200 + 64'(idx * 4));
      acc = if_valid && d32_if_ready;
      cycle();
      if (acc) idx++;
      if (c == 1) check("bp.if_ready_fall", 64'(d32_if_ready), 64'd0);
    end
    check("bp.all_accepted", 64'(idx), 64'd4);
    drive(1'b0, 32'h0, 64'h0);
    cycle();
    cycle();

    // Flush while full with a new instruction on offer
    ex_ready = 1'b0;
    drive(1'b1, 32'h0050_0313, 64'h300);
    cycle();
    drive(1'b1, 32'h0060_0393, 64'h304);
    cycle();
    check("flush.pre_full", 64'(d32_if_ready), 64'd0);
    drive(1'b1, 32'h0070_0413, 64'h308);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush.valid", 64'(d32_ex_valid), 64'd0);
    check("flush.ready", 64'(d32_if_ready), 64'd1);
    drive(1'b0, 32'h0, 64'h0);
    ex_ready = 1'b1;
    cycle();
    cycle();

    // Asynchronous reset mid-operation
    ex_ready = 1'b0;
    drive(1'b1, 32'h0080_0493, 64'h400);
    cycle();
    drive(1'b1, 32'h0090_0513, 64'h404);
    cycle();
    drive(1'b0, 32'h0, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid32", 64'(d32_ex_valid), 64'd0);
    check("arst.ready32", 64'(d32_if_ready), 64'd1);
    check("arst.valid64", 64'(d64_ex_valid), 64'd0);
    check("arst.imm32",   64'(d32_imm),      64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      if_valid = ($urandom_range(0, 9) < 7);
      ex_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 31) == 0);
      inst     = rand_inst();
      pc       = {$urandom, $urandom} & ~64'h3;
      cycle();
    end
    flush    = 1'b0;
    if_valid = 1'b0;
    ex_ready = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    check("drain.valid32", 64'(d32_ex_valid), 64'd0);
    check("drain.valid64", 64'(d64_ex_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
